// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants, register decode and cause encoding for irq_source_ctrl
package irq_pkg;

    // Byte offsets of the register map.
    localparam logic [4:0] OFF_MSIP        = 5'h00;
    localparam logic [4:0] OFF_MTIMECMP_LO = 5'h04;
    localparam logic [4:0] OFF_MTIMECMP_HI = 5'h08;
    localparam logic [4:0] OFF_MTIME_LO    = 5'h0C;
    localparam logic [4:0] OFF_MTIME_HI    = 5'h10;
    localparam logic [4:0] OFF_IE          = 5'h14;
    localparam logic [4:0] OFF_IP          = 5'h18;

    // Bit positions inside IE and IP.
    localparam int IRQ_SW    = 0;
    localparam int IRQ_TIMER = 1;
    localparam int IRQ_EXT   = 2;

    // mcause encodings.
    localparam logic [31:0] IRQ_FLAG  = 32'h8000_0000;
    localparam logic [31:0] CAUSE_MSI = 32'd3;
    localparam logic [31:0] CAUSE_MTI = 32'd7;
    localparam logic [31:0] CAUSE_MEI = 32'd11;

    typedef enum logic [2:0] {
        REG_MSIP,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_MT_LO,
        REG_MT_HI,
        REG_IE,
        REG_IP,
        REG_NONE
    } reg_sel_e;

    // Decode on the word index only; byte-lane bits are not significant.
    function automatic reg_sel_e decode_reg(input logic [2:0] word);
        reg_sel_e sel;
        sel = REG_NONE;
        if (word == OFF_MSIP[4:2])             sel = REG_MSIP;
        else if (word == OFF_MTIMECMP_LO[4:2]) sel = REG_CMP_LO;
        else if (word == OFF_MTIMECMP_HI[4:2]) sel = REG_CMP_HI;
        else if (word == OFF_MTIME_LO[4:2])    sel = REG_MT_LO;
        else if (word == OFF_MTIME_HI[4:2])    sel = REG_MT_HI;
        else if (word == OFF_IE[4:2])          sel = REG_IE;
        else if (word == OFF_IP[4:2])          sel = REG_IP;
        return sel;
    endfunction

    // Fixed priority ext > sw > timer; zero when nothing is active.
    function automatic logic [31:0] cause_of(input logic [2:0] active);
        logic [31:0] cause;
        cause = 32'h0;
        if (active[IRQ_EXT])        cause = IRQ_FLAG | CAUSE_MEI;
        else if (active[IRQ_SW])    cause = IRQ_FLAG | CAUSE_MSI;
        else if (active[IRQ_TIMER]) cause = IRQ_FLAG | CAUSE_MTI;
        return cause;
    endfunction

endpackage

// File: rtl/irq_source_ctrl_if.sv
// rtl/irq_source_ctrl_if.sv - word-wide data-memory bus into the interrupt source block
// Signals: bus_addr (byte offset), bus_we/bus_re (one-cycle strobes), bus_wdata,
//          bus_rdata/bus_rvalid (returned the cycle after bus_re).
interface irq_source_ctrl_if;
    logic [4:0]  bus_addr;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;

    modport master (
        output bus_addr, bus_we, bus_re, bus_wdata,
        input  bus_rdata, bus_rvalid
    );

    modport slave (
        input  bus_addr, bus_we, bus_re, bus_wdata,
        output bus_rdata, bus_rvalid
    );
endinterface

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - multi-flop synchroniser followed by a rising-edge pulse
// Ports: clk, rst (async, active-high), async_in (unsynchronised line),
//        rise (one-cycle pulse on a synchronised 0->1 transition).
module irq_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              edge_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            edge_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~edge_q;

endmodule

// File: rtl/irq_source_ctrl.sv
// rtl/irq_source_ctrl.sv - machine timer, software and external interrupt sources feeding one irq level
// Ports: clk, rst (async, active-high), bus (register access, slave side),
//        ext_irq_async (async external line, rising edge significant),
//        irq_ack (exception unit took an interrupt), irq (level), irq_cause (mcause).
module irq_source_ctrl
    import irq_pkg::*;
#(
    parameter int PRESCALE    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    irq_source_ctrl_if.slave   bus,
    input  logic               ext_irq_async,
    input  logic               irq_ack,
    output logic               irq,
    output logic [31:0]        irq_cause
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] presc_cnt;
    logic             tick;
    logic [63:0]      mtime;
    logic [63:0]      mtime_nxt;
    logic [63:0]      mtimecmp;
    logic             msip;
    logic             timer_pend;
    logic             ext_pend;
    logic             ext_rise;
    logic             ext_clr;
    logic [2:0]       ie;
    logic [2:0]       ip;
    logic [2:0]       active;
    logic [31:0]      rd_mux;
    reg_sel_e         sel;
    logic [1:0]       unused_addr_bits;

    assign unused_addr_bits = bus.bus_addr[1:0];
    assign sel              = decode_reg(bus.bus_addr[4:2]);

    irq_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk      (clk),
        .rst      (rst),
        .async_in (ext_irq_async),
        .rise     (ext_rise)
    );

    // With PRESCALE=1 the counter is pinned at 0 and tick is permanently high.
    assign tick = (presc_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) presc_cnt <= '0;
        else     presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
    end

    // A half-word write replaces that half; the other half keeps its
    // pre-increment value so no carry crosses into or out of the written half.
    always_comb begin
        mtime_nxt = tick ? mtime + 64'd1 : mtime;
        if (bus.bus_we && sel == REG_MT_LO) mtime_nxt = {mtime[63:32], bus.bus_wdata};
        if (bus.bus_we && sel == REG_MT_HI) mtime_nxt = {bus.bus_wdata, mtime[31:0]};
    end

    // Edge detection beats a same-cycle clear so an edge is never lost.
    assign ext_clr = irq_ack || (bus.bus_we && sel == REG_IP && bus.bus_wdata[IRQ_EXT]);

    assign ip     = {ext_pend, timer_pend, msip};
    assign active = ip & ie;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime      <= 64'h0;
            mtimecmp   <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip       <= 1'b0;
            ie         <= 3'b000;
            ext_pend   <= 1'b0;
            timer_pend <= 1'b0;
            irq        <= 1'b0;
            irq_cause  <= 32'h0;
        end else begin
            mtime      <= mtime_nxt;
            timer_pend <= (mtime >= mtimecmp);
            if (ext_rise)     ext_pend <= 1'b1;
            else if (ext_clr) ext_pend <= 1'b0;
            if (bus.bus_we) begin
                case (sel)
                    REG_MSIP:   msip           <= bus.bus_wdata[0];
                    REG_CMP_LO: mtimecmp[31:0]  <= bus.bus_wdata;
                    REG_CMP_HI: mtimecmp[63:32] <= bus.bus_wdata;
                    REG_IE:     ie             <= bus.bus_wdata[2:0];
                    default:    ;
                endcase
            end
            irq       <= |active;
            irq_cause <= cause_of(active);
        end
    end

    // Read mux sees pre-write register values, so a simultaneous write and
    // read returns the old contents.
    always_comb begin
        rd_mux = 32'h0;
        case (sel)
            REG_MSIP:   rd_mux = {31'h0, msip};
            REG_CMP_LO: rd_mux = mtimecmp[31:0];
            REG_CMP_HI: rd_mux = mtimecmp[63:32];
            REG_MT_LO:  rd_mux = mtime[31:0];
            REG_MT_HI:  rd_mux = mtime[63:32];
            REG_IE:     rd_mux = {29'h0, ie};
            REG_IP:     rd_mux = {29'h0, ip};
            default:    rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.bus_rdata  <= 32'h0;
            bus.bus_rvalid <= 1'b0;
        end else begin
            bus.bus_rdata  <= bus.bus_re ? rd_mux : 32'h0;
            bus.bus_rvalid <= bus.bus_re;
        end
    end

endmodule

// File: tb/tb_irq_source_ctrl.sv
// tb/tb_irq_source_ctrl.sv - self-checking bench for irq_source_ctrl
module tb_irq_source_ctrl;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ext_irq_async;
    logic        irq_ack;
    logic        irq;
    logic [31:0] irq_cause;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    // Reference model state
    logic [63:0] m_base;
    int          m_cyc;
    logic [63:0] cmp_m;
    logic        msip_m;
    logic        ext_m;
    logic [2:0]  ie_m;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    irq_source_ctrl_if bus ();

    irq_source_ctrl #(
        .PRESCALE    (1),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus.slave),
        .ext_irq_async (ext_irq_async),
        .irq_ack       (irq_ack),
        .irq           (irq),
        .irq_cause     (irq_cause)
    );

    // mtime after edge j, given the last write established m_base at edge m_cyc.
    function automatic logic [63:0] mtime_at(input int j);
        return m_base + 64'(j - m_cyc);
    endfunction

    function automatic logic [31:0] exp_cause(input logic e, input logic t, input logic s);
        if (e) return 32'h8000_000B;
        if (s) return 32'h8000_0003;
        if (t) return 32'h8000_0007;
        return 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        logic [63:0] cur;
        bus.bus_addr  = a;
        bus.bus_wdata = d;
        bus.bus_we    = 1'b1;
        tick();
        bus.bus_we    = 1'b0;
        cur = mtime_at(cyc - 1);
        case (a)
            5'h00: msip_m = d[0];
            5'h04: cmp_m[31:0] = d;
            5'h08: cmp_m[63:32] = d;
            5'h0C: begin m_base = {cur[63:32], d}; m_cyc = cyc; end
            5'h10: begin m_base = {d, cur[31:0]}; m_cyc = cyc; end
            5'h14: ie_m = d[2:0];
            5'h18: if (d[2]) ext_m = 1'b0;
            default: ;
        endcase
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        bus.bus_addr = a;
        bus.bus_re   = 1'b1;
        tick();
        bus.bus_re   = 1'b0;
        chk("rvalid", 64'(bus.bus_rvalid), 64'd1);
        d = bus.bus_rdata;
    endtask

    task automatic ack_pulse();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        ext_m   = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] t_lo;
        logic [63:0] mt;
        logic        tp;
        logic [2:0]  act;
        int          e;
        int          op;

        rst           = 1'b1;
        ext_irq_async = 1'b0;
        irq_ack       = 1'b0;
        bus.bus_addr  = 5'h0;
        bus.bus_we    = 1'b0;
        bus.bus_re    = 1'b0;
        bus.bus_wdata = 32'h0;
        cmp_m  = 64'hFFFF_FFFF_FFFF_FFFF;
        msip_m = 1'b0;
        ext_m  = 1'b0;
        ie_m   = 3'b000;
        m_base = 64'h0;
        repeat (3) tick();
        chk("rst_irq", 64'(irq), 64'd0);
        chk("rst_cause", 64'(irq_cause), 64'd0);
        chk("rst_rdata", 64'(bus.bus_rdata), 64'd0);
        chk("rst_rvalid", 64'(bus.bus_rvalid), 64'd0);
        rst   = 1'b0;
        m_cyc = cyc;

        // Reset register contents
        rd(5'h00, d); chk("rst_msip", 64'(d), 64'd0);
        rd(5'h04, d); chk("rst_cmp_lo", 64'(d), 64'hFFFF_FFFF);
        rd(5'h08, d); chk("rst_cmp_hi", 64'(d), 64'hFFFF_FFFF);
        rd(5'h0C, d); mt = mtime_at(cyc - 1); chk("rst_mtime_lo", 64'(d), 64'(mt[31:0]));
        rd(5'h10, d); chk("rst_mtime_hi", 64'(d), 64'd0);
        rd(5'h14, d); chk("rst_ie", 64'(d), 64'd0);
        rd(5'h18, d); chk("rst_ip", 64'(d), 64'd0);
        rd(5'h1C, d); chk("rst_unmapped", 64'(d), 64'd0);

        wr(5'h14, 32'h7);
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("idle_irq", 64'(irq), 64'd0);
        end

        // Unmapped write ignored, simultaneous read/write returns old value
        wr(5'h1C, 32'hFFFF_FFFF);
        rd(5'h1C, d); chk("unmapped_wr", 64'(d), 64'd0);
        bus.bus_addr  = 5'h14;
        bus.bus_wdata = 32'h2;
        bus.bus_we    = 1'b1;
        bus.bus_re    = 1'b1;
        tick();
        bus.bus_we    = 1'b0;
        bus.bus_re    = 1'b0;
        ie_m = 3'b010;
        chk("rw_same_cycle_old", 64'(bus.bus_rdata), 64'd7);
        rd(5'h14, d); chk("rw_same_cycle_new", 64'(d), 64'd2);

        // Timer compare latency
        mt   = mtime_at(cyc);
        t_lo = mt[31:0] + 32'd12;
        wr(5'h08, 32'h0);
        wr(5'h04, t_lo);
        e = m_cyc + int'(t_lo);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("timer_irq", 64'(irq), 64'(cyc >= e + 2));
            chk("timer_cause", 64'(irq_cause), (cyc >= e + 2) ? 64'h8000_0007 : 64'h0);
        end
        ack_pulse();
        tick(); tick();
        chk("timer_ack_ignored", 64'(irq), 64'd1);
        wr(5'h08, 32'hFFFF_FFFF);
        chk("timer_clr_0", 64'(irq), 64'd1);
        tick();
        chk("timer_clr_1", 64'(irq), 64'd1);
        tick();
        chk("timer_clr_2", 64'(irq), 64'd0);

        // External edge latency, ack, no re-trigger while held
        wr(5'h14, 32'h4);
        ext_irq_async = 1'b1;
        repeat (SYNC + 1) tick();
        chk("ext_lat_early", 64'(irq), 64'd0);
        tick();
        ext_m = 1'b1;
        chk("ext_lat", 64'(irq), 64'd1);
        chk("ext_cause", 64'(irq_cause), 64'h8000_000B);
        ack_pulse();
        chk("ext_ack_0", 64'(irq), 64'd1);
        tick();
        chk("ext_ack_1", 64'(irq), 64'd0);
        chk("ext_ack_cause", 64'(irq_cause), 64'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("ext_held", 64'(irq), 64'd0);
        end
        ext_irq_async = 1'b0;
        repeat (5) tick();

        // Edge arriving in the same cycle as an IP clear
        ext_irq_async = 1'b1;
        repeat (SYNC) tick();
        wr(5'h18, 32'h4);
        ext_m = 1'b1;
        rd(5'h18, d); chk("edge_beats_clear", 64'(d), 64'h4);
        chk("edge_beats_clear_irq", 64'(irq), 64'd1);
        ext_irq_async = 1'b0;
        ack_pulse();
        repeat (5) tick();
        chk("ext_cleared", 64'(irq), 64'd0);

        // Priority sw over timer, ext over both
        wr(5'h00, 32'h1);
        wr(5'h08, 32'h0);
        wr(5'h04, 32'h0);
        wr(5'h14, 32'h7);
        repeat (3) tick();
        chk("prio_sw_irq", 64'(irq), 64'd1);
        chk("prio_sw", 64'(irq_cause), 64'h8000_0003);
        ext_irq_async = 1'b1;
        repeat (SYNC + 2) tick();
        ext_m = 1'b1;
        chk("prio_ext", 64'(irq_cause), 64'h8000_000B);
        ext_irq_async = 1'b0;
        ack_pulse();
        tick();
        chk("prio_back_sw", 64'(irq_cause), 64'h8000_0003);
        rd(5'h18, d); chk("prio_ip", 64'(d), 64'h3);

        // mtime wrap and write-wins on an increment cycle
        wr(5'h0C, 32'hFFFF_FFFF);
        wr(5'h10, 32'hFFFF_FFFF);
        repeat (3) tick();
        rd(5'h10, d); chk("wrap_hi", 64'(d), 64'd0);
        mt = mtime_at(cyc - 1);
        chk("wrap_hi_model", 64'(d), 64'(mt[63:32]));
        rd(5'h0C, d); mt = mtime_at(cyc - 1); chk("wrap_lo", 64'(d), 64'(mt[31:0]));
        wr(5'h0C, 32'h1234_5678);
        rd(5'h0C, d); chk("write_wins", 64'(d), 64'h1234_5678);

        // Randomised register traffic against the model
        wr(5'h0C, 32'd1000);
        wr(5'h10, 32'd0);
        wr(5'h08, 32'd0);
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 5));
            case (op)
                0: wr(5'h00, $urandom);
                1: wr(5'h14, $urandom);
                2: wr(5'h04, ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 10))
                                                          : (32'hFFFF_0000 | 32'($urandom_range(0, 65535))));
                3: begin
                    ext_irq_async = 1'b1;
                    repeat (SYNC + 1) tick();
                    ext_irq_async = 1'b0;
                    ext_m = 1'b1;
                end
                4: ack_pulse();
                default: wr(5'h18, $urandom);
            endcase
            repeat (3) tick();
            tp  = (mtime_at(cyc) >= cmp_m);
            act = {ext_m, tp, msip_m} & ie_m;
            chk("rand_irq", 64'(irq), 64'(|act));
            chk("rand_cause", 64'(irq_cause), 64'(exp_cause(act[2], act[1], act[0])));
            rd(5'h18, d); chk("rand_ip", 64'(d), 64'({ext_m, tp, msip_m}));
            rd(5'h14, d); chk("rand_ie", 64'(d), 64'(ie_m));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irq_source_ctrl.md
Name: irq_source_ctrl

Overview:
Machine-level interrupt source block directly upstream of the core's exception/CSR unit. It holds a 64-bit machine timer (mtime/mtimecmp), a software-interrupt bit and a synchronised, edge-detected external interrupt line. It combines enabled pending sources into the single level `irq` consumed by the exception unit's `interrupt` input, plus a cause code. Registers are accessed over the core's word-wide data-memory bus.

Parameters:
PRESCALE, 1, clk cycles per mtime increment (≥1).
SYNC_STAGES, 2, flops in the ext_irq_async synchroniser (≥2).

Ports:
clk  in  1  clock
rst  in  1  reset
bus_addr  in  5  byte offset within the block; bits [1:0] ignored
bus_we  in  1  write strobe, one cycle
bus_re  in  1  read strobe, one cycle
bus_wdata  in  32  write data
bus_rdata  out  32  read data, valid the cycle after bus_re
bus_rvalid  out  1  pulses the cycle after bus_re
ext_irq_async  in  1  external interrupt line, asynchronous, rising-edge significant
irq_ack  in  1  one-cycle pulse from the exception unit when it takes an interrupt
irq  out  1  level, to the exception unit's interrupt input
irq_cause  out  32  mcause value of the highest-priority pending+enabled source

Behaviour:
- Reset: rst asynchronous, active-high; clock clk. Reset values: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, ie=3'b000, ext_pend=0, prescale counter=0, synchroniser and edge flops=0, bus_rdata=0, bus_rvalid=0, irq=0, irq_cause=0.
- Register map (offset: content):
  - 0x00 MSIP: bit0 is the sw source, R/W.
  - 0x04/0x08 MTIMECMP lo/hi: R/W.
  - 0x0C/0x10 MTIME lo/hi: R/W.
  - 0x14 IE: bits[2:0] = {ext, timer, sw}, R/W.
  - 0x18 IP: bits[2:0] = {ext_pend, timer_pend, msip}, read-only except write-1-to-clear of bit2.
  - Unmapped offsets read 0 and ignore writes. Unused register bits read 0.
- Timer:
  - Prescale counter counts 0..PRESCALE-1. mtime increments by 1 on the cycle the counter wraps.
  - mtime wraps 2^64-1 to 0 silently.
  - A bus write to MTIME lo or hi in the same cycle as an increment: the write wins for the written half. The other half keeps its pre-increment value, with no carry propagation.
  - timer_pend = (mtime >= mtimecmp), unsigned 64-bit compare, registered, so it updates one cycle after mtime/mtimecmp change.
  - timer_pend is a level. It is cleared only by raising mtimecmp or lowering mtime, never by irq_ack.
- External source:
  - ext_irq_async passes through SYNC_STAGES flops, then one edge flop.
  - A synchronised 0→1 transition sets ext_pend.
  - irq_ack or an IP write with bit2=1 clears ext_pend.
  - A new edge in the same cycle as a clear wins, so ext_pend stays 1.
  - Latency from an async rising edge to irq: SYNC_STAGES+2 cycles when enabled.
- Software source: msip is a level, cleared only by writing 0 to MSIP.
- Output:
  - active = IP & IE.
  - irq and irq_cause are registered from active, one cycle after it changes.
  - Priority: ext > sw > timer. irq_cause = 32'h8000000B, 32'h80000003 or 32'h80000007 respectively; 0 when none.
  - Global enable (mstatus.MIE) is not applied here; the exception unit gates it.
- Bus:
  - Reads are registered: bus_rdata/bus_rvalid valid exactly one cycle after bus_re.
  - bus_we and bus_re asserted together: the write executes and the read returns the pre-write value.
  - Back-to-back accesses every cycle are supported; no stalls.
- irq_ack: affects only ext_pend. An irq_ack while ext_pend=0 is ignored.

Decomposition:
- Shared package `irq_pkg`:
  - register offset constants.
  - IE/IP bit indices.
  - Cause constants CAUSE_MSI=3, CAUSE_MTI=7, CAUSE_MEI=11 and the interrupt flag 32'h80000000.
- One sub-module is natural: `irq_sync_edge`, the parameterised SYNC_STAGES synchroniser plus rising-edge pulse.
- Timer, registers and priority logic stay in the top.

Test Plan:
- Reset → all reads 0 except MTIMECMP lo/hi = 32'hFFFFFFFF; irq=0 for 100 cycles with IE=7.
- PRESCALE=1: write MTIMECMP hi=0 then lo=20, IE=3'b010 → irq=1 and irq_cause=32'h80000007 from the cycle mtime reaches 20 plus 2. Write MTIMECMP hi=32'hFFFFFFFF → irq=0 two cycles later. irq_ack has no effect on timer_pend.
- IE=3'b100, rising edge on ext_irq_async → irq=1 after 4 cycles (SYNC_STAGES=2), cause 32'h8000000B. irq_ack pulse → irq=0 next-but-one cycle. Line held high produces no re-trigger.
- Simultaneous ext edge and IP write of 32'h4 → ext_pend remains 1.
- MSIP=1 and timer pending, IE=7, then an ext edge → cause changes 32'h80000003 to 32'h8000000B. After irq_ack, cause returns to 32'h80000003.
- Write MTIME lo=32'hFFFFFFFF, hi=32'hFFFFFFFF, then idle → mtime reads 0 after the wrap. Writing MTIME lo in the cycle of an increment leaves the written value, not value+1.
